// File: rtl/mem_arbiter2_if.sv
// mem_interface: request/ready handshake bus between a bus master and the SDRAM controller.
// The master holds request high for a transfer; each cycle with ready & request moves one word.
interface mem_interface #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              request;
    logic              write_enable;
    logic [ADDR_W-1:0] address;
    logic              last4;
    logic [DATA_W-1:0] data_write;
    logic              ready;
    logic [DATA_W-1:0] data_read;

    modport master (
        output request, write_enable, address, last4, data_write,
        input  ready, data_read
    );

    modport slave (
        input  request, write_enable, address, last4, data_write,
        output ready, data_read
    );
endinterface

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: round-robin two-master arbiter on the mem_interface bus with a per-grant burst limit.
// Optional MEM_ARB_STATS_EN adds grant/cut statistic counters and their output ports.
module mem_arbiter2 #(
    parameter int MAX_BURST = 64,
    parameter int STAT_W    = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_interface.slave  m0,
    mem_interface.slave  m1,
    mem_interface.master mem
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1,
    output logic [STAT_W-1:0] cut_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1,
        RELEASE
    } state_t;

    // MAX_BURST = 0 means unlimited; the beat counter then just saturates at all ones.
    localparam int BEAT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX =
        (MAX_BURST > 0) ? BEAT_W'(MAX_BURST) : {BEAT_W{1'b1}};

    state_t            state, state_nxt;
    logic              owner, owner_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic              started, started_nxt;
    logic              cut, cut_nxt;

    logic              in_grant;
    logic              sel1;
    logic              req_cur;
    logic              mem_req;
    logic              fire;
    logic              limit_hit;
    logic [BEAT_W-1:0] beat_inc;

    assign in_grant = (state == GRANT0) || (state == GRANT1);
    // RELEASE keeps the owner's address/data on the bus for its trailing write beat.
    assign sel1      = (state == GRANT1) || ((state == RELEASE) && owner);
    assign req_cur   = sel1 ? m1.request : m0.request;
    assign mem_req   = in_grant && req_cur && !cut;
    assign fire      = mem_req && mem.ready;
    assign beat_inc  = (beat == BEAT_MAX) ? beat : beat + 1'b1;
    assign limit_hit = (MAX_BURST != 0) && fire && (beat_inc == BEAT_MAX);

    assign mem.request      = mem_req;
    assign mem.address      = (state == IDLE) ? '0 : (sel1 ? m1.address : m0.address);
    assign mem.write_enable = (state != IDLE) && (sel1 ? m1.write_enable : m0.write_enable);
    assign mem.last4        = (state != IDLE) && (sel1 ? m1.last4 : m0.last4);
    assign mem.data_write   = (state == IDLE) ? '0 : (sel1 ? m1.data_write : m0.data_write);

    assign m0.ready     = (state == GRANT0) && mem.ready && !cut;
    assign m1.ready     = (state == GRANT1) && mem.ready && !cut;
    assign m0.data_read = mem.data_read;
    assign m1.data_read = mem.data_read;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            owner   <= 1'b1;
            beat    <= '0;
            started <= 1'b0;
            cut     <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            beat    <= beat_nxt;
            started <= started_nxt;
            cut     <= cut_nxt;
        end
    end

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        beat_nxt    = beat;
        started_nxt = started;
        cut_nxt     = cut;

        unique case (state)
            IDLE: begin
                if (m0.request && (!m1.request || owner)) begin
                    state_nxt   = GRANT0;
                    owner_nxt   = 1'b0;
                    beat_nxt    = '0;
                    started_nxt = 1'b0;
                end else if (m1.request) begin
                    state_nxt   = GRANT1;
                    owner_nxt   = 1'b1;
                    beat_nxt    = '0;
                    started_nxt = 1'b0;
                end
            end

            GRANT0, GRANT1: begin
                if (fire) begin
                    beat_nxt    = beat_inc;
                    started_nxt = 1'b1;
                end
                if (limit_hit) begin
                    cut_nxt = 1'b1;
                end
                // Master gave up, slave closed the transfer, or burst limit reached.
                if (!req_cur || (started && !mem.ready) || limit_hit) begin
                    state_nxt = RELEASE;
                end
            end

            RELEASE: begin
                cut_nxt   = 1'b0;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    logic grant_evt0;
    logic grant_evt1;

    assign grant_evt0 = (state == IDLE) && (state_nxt == GRANT0);
    assign grant_evt1 = (state == IDLE) && (state_nxt == GRANT1);

    // Counters wrap naturally at 2^STAT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            cut_cnt    <= '0;
        end else begin
            if (grant_evt0) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (grant_evt1) grant_cnt1 <= grant_cnt1 + 1'b1;
            if (limit_hit)  cut_cnt    <= cut_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter2.sv
// Testbench for mem_arbiter2: two instances (default burst limit and MAX_BURST=4), master/slave models,
// and a scoreboard that pairs every master-side transfer with the word the bench expects.
module tb_mem_arbiter2;

    localparam int NM = 4;   // masters 0,1 on arbiter A; masters 2,3 on arbiter B

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_interface m0a (), m1a (), mema ();
    mem_interface m0b (), m1b (), memb ();

    // master-side wires
    logic [NM-1:0] req, we, l4, rdy;
    logic [23:0]   adr  [NM];
    logic [31:0]   wdat [NM];
    logic [31:0]   rdat [NM];
    // slave-side wires
    logic [1:0]    mreq, mwe, ml4, srdy;
    logic [23:0]   madr [2];
    logic [31:0]   mwd  [2];

    assign m0a.request = req[0]; assign m0a.write_enable = we[0]; assign m0a.address = adr[0];
    assign m0a.last4   = l4[0];  assign m0a.data_write   = wdat[0];
    assign m1a.request = req[1]; assign m1a.write_enable = we[1]; assign m1a.address = adr[1];
    assign m1a.last4   = l4[1];  assign m1a.data_write   = wdat[1];
    assign m0b.request = req[2]; assign m0b.write_enable = we[2]; assign m0b.address = adr[2];
    assign m0b.last4   = l4[2];  assign m0b.data_write   = wdat[2];
    assign m1b.request = req[3]; assign m1b.write_enable = we[3]; assign m1b.address = adr[3];
    assign m1b.last4   = l4[3];  assign m1b.data_write   = wdat[3];
    assign rdy[0] = m0a.ready; assign rdat[0] = m0a.data_read;
    assign rdy[1] = m1a.ready; assign rdat[1] = m1a.data_read;
    assign rdy[2] = m0b.ready; assign rdat[2] = m0b.data_read;
    assign rdy[3] = m1b.ready; assign rdat[3] = m1b.data_read;

    assign mreq[0] = mema.request; assign mwe[0] = mema.write_enable; assign ml4[0] = mema.last4;
    assign madr[0] = mema.address; assign mwd[0] = mema.data_write;
    assign mreq[1] = memb.request; assign mwe[1] = memb.write_enable; assign ml4[1] = memb.last4;
    assign madr[1] = memb.address; assign mwd[1] = memb.data_write;
    // slave returns a word derived from the address it is currently given
    assign mema.ready = srdy[0]; assign mema.data_read = srdy[0] ? {8'hD0, madr[0]} : 32'h0;
    assign memb.ready = srdy[1]; assign memb.data_read = srdy[1] ? {8'hD0, madr[1]} : 32'h0;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] gc0_a, gc1_a, cut_a, gc0_b, gc1_b, cut_b;
`endif

    mem_arbiter2 u_dut_a (
        .clk(clk), .reset_n(reset_n), .m0(m0a), .m1(m1a), .mem(mema)
`ifdef MEM_ARB_STATS_EN
        , .grant_cnt0(gc0_a), .grant_cnt1(gc1_a), .cut_cnt(cut_a)
`endif
    );

    mem_arbiter2 #(.MAX_BURST(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .m0(m0b), .m1(m1b), .mem(memb)
`ifdef MEM_ARB_STATS_EN
        , .grant_cnt0(gc0_b), .grant_cnt1(gc1_b), .cut_cnt(cut_b)
`endif
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          m;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    // ---------------- stimulus control (written only by the main sequence) ----------------
    int          m_n    [NM];
    int          m_seq  [NM];
    logic        m_we   [NM];
    logic [23:0] m_base [NM];
    logic [31:0] m_wbase[NM];
    int          sl_delay[2];
    int          sl_beats[2];

    // ---------------- master and slave models ----------------
    int done [NM];
    int last_seq [NM];
    int s_wait [2];
    int s_beats[2];
    logic s_req [2];

    initial begin
        req = '0; we = '0; l4 = 4'b1010; srdy = '0;
        for (int i = 0; i < NM; i++) begin
            done[i] = 0; last_seq[i] = 0; adr[i] = '0; wdat[i] = '0;
        end
        for (int b = 0; b < 2; b++) begin
            s_wait[b] = 0; s_beats[b] = 0; s_req[b] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NM; i++)
                if (req[i] && rdy[i]) done[i]++;
            for (int b = 0; b < 2; b++) begin
                s_req[b] = mreq[b];
                if (mreq[b] && srdy[b]) s_beats[b]++;
                if (!mreq[b]) begin
                    s_wait[b] = 0; s_beats[b] = 0;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NM; i++) begin
                if (m_seq[i] != last_seq[i]) begin
                    last_seq[i] = m_seq[i];
                    done[i]     = 0;
                end
                req[i]  = (done[i] < m_n[i]);
                we[i]   = m_we[i];
                adr[i]  = m_base[i] + 24'(done[i]);
                wdat[i] = m_wbase[i] + 32'(done[i]);
            end
            for (int b = 0; b < 2; b++) begin
                if (!s_req[b]) srdy[b] = 1'b0;
                else if (s_wait[b] < sl_delay[b]) begin
                    s_wait[b]++; srdy[b] = 1'b0;
                end else srdy[b] = (s_beats[b] < sl_beats[b]);
            end
        end
    end

    // scoreboard monitor: every master-side transfer must match the oldest pending word of that master
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NM; i++) begin
                if (req[i] && rdy[i]) begin
                    int idx;
                    logic [31:0] act;
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++)
                        if (sb[k].m == i) begin
                            idx = k;
                            break;
                        end
                    act = we[i] ? mwd[i/2] : rdat[i];
                    check($sformatf("sb_pending_m%0d", i), 32'(idx >= 0), 32'd1);
                    if (idx >= 0) begin
                        check($sformatf("sb_data_m%0d", i), act, sb[idx].d);
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic w, input int n,
                         input logic [23:0] base, input logic [31:0] wbase);
        m_we[i] = w; m_n[i] = n; m_base[i] = base; m_wbase[i] = wbase;
        m_seq[i]++;
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.m = i;
            e.d = w ? (wbase + 32'(k)) : {8'hD0, base + 24'(k)};
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int i, input int n, input string name);
        int c;
        c = 0;
        do begin
            step();
            c++;
        end while (done[i] < n && c < 200);
        check(name, 32'(done[i] >= n), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   c;
        logic seen;
        reset_n = 1'b0;
        for (int i = 0; i < NM; i++) begin
            m_n[i] = 0; m_seq[i] = 0; m_we[i] = 1'b0; m_base[i] = '0; m_wbase[i] = '0;
        end
        sl_delay[0] = 0; sl_delay[1] = 0; sl_beats[0] = 1000; sl_beats[1] = 1000;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // reset state
        check("rst_mem_request", 32'(mreq[0]), 0);
        check("rst_mem_address", 32'(madr[0]), 0);
        check("rst_mem_wdata",   mwd[0], 0);
        check("rst_mem_we_l4",   {30'd0, mwe[0], ml4[0]}, 0);
        check("rst_ready",       32'(rdy), 0);

        // 1: m0 alone reads 8 words, slave ready after 2 cycles
        sl_delay[0] = 2; sl_beats[0] = 1000;
        issue(0, 1'b0, 8, 24'h000100, 32'h0);
        step();
        check("t1_req_not_yet", 32'(mreq[0]), 0);
        step();
        check("t1_req_latency", 32'(mreq[0]), 1);
        check("t1_address",     32'(madr[0]), 32'h100);
        c = 0; seen = 1'b0;
        while (done[0] < 8 && c < 200) begin
            step();
            if (rdy[1]) seen = 1'b1;
            c++;
        end
        check("t1_done",      32'(done[0]), 8);
        check("t1_m1_ready",  32'(seen), 0);
        repeat (4) step();

        // 2: both request together after reset -> m0 first, then RELEASE, then m1
        do_reset();
        sl_delay[0] = 0;
        issue(0, 1'b0, 3, 24'h000200, 32'h0);
        issue(1, 1'b0, 3, 24'h000300, 32'h0);
        step();
        check("t2_idle_req", 32'(mreq[0]), 0);
        step();
        check("t2_first_addr", 32'(madr[0]), 32'h200);
        check("t2_first_l4",   32'(ml4[0]), 0);
        wait_done(0, 3, "t2_m0_done");
        step();
        check("t2_drop_req", 32'(mreq[0]), 0);
        step();
        check("t2_release_req", 32'(mreq[0]), 0);
        step();
        check("t2_idle2_req", 32'(mreq[0]), 0);
        step();
        check("t2_m1_req",  32'(mreq[0]), 1);
        check("t2_m1_addr", 32'(madr[0]), 32'h300);
        check("t2_m1_l4",   32'(ml4[0]), 1);
        wait_done(1, 3, "t2_m1_done");
        repeat (4) step();

        // 4: m0 writes 3 words, slave ready 3 cycles; trailing data_write visible in RELEASE
        sl_delay[0] = 0; sl_beats[0] = 3;
        issue(0, 1'b1, 3, 24'h000400, 32'hA000_0000);
        wait_done(0, 3, "t4_done");
        step();
        check("t4_drop_req", 32'(mreq[0]), 0);
        step();
        check("t4_release_req",   32'(mreq[0]), 0);
        check("t4_trailing_data", mwd[0], 32'hA000_0003);
        check("t4_release_we",    32'(mwe[0]), 1);
        repeat (4) step();

        // 5: slave ends after 2 of 6 reads -> RELEASE and re-grant with beat=0
        sl_delay[0] = 0; sl_beats[0] = 2;
        issue(0, 1'b0, 6, 24'h000600, 32'h0);
        wait_done(0, 2, "t5_first2");
        step();
        check("t5_hold_req",   32'(mreq[0]), 1);
        check("t5_hold_ready", 32'(rdy[0]), 0);
        step();
        check("t5_release_req", 32'(mreq[0]), 0);
        step();
        check("t5_idle_req", 32'(mreq[0]), 0);
        step();
        check("t5_regrant_req",  32'(mreq[0]), 1);
        check("t5_regrant_addr", 32'(madr[0]), 32'h602);
        check("t5_regrant_beat", 32'(u_dut_a.beat), 0);
        wait_done(0, 6, "t5_done");
        repeat (4) step();

        // 3: MAX_BURST=4 instance: m0 wants 10, m1 waiting -> cut after 4, m1 next
        sl_delay[1] = 0; sl_beats[1] = 1000;
        issue(2, 1'b0, 10, 24'h000800, 32'h0);
        issue(3, 1'b0, 2,  24'h000900, 32'h0);
        wait_done(2, 4, "t3_four_beats");
        step();
        check("t3_cut_ready", 32'(rdy[2]), 0);
        check("t3_cut_req",   32'(mreq[1]), 0);
`ifdef MEM_ARB_STATS_EN
        check("t3_cut_cnt1", 32'(cut_b), 1);
`endif
        c = 0;
        while (done[3] < 1 && c < 50) begin
            step();
            c++;
        end
        check("t3_m1_granted",   32'(done[3]), 1);
        check("t3_m0_held_at_4", 32'(done[2]), 4);
        wait_done(2, 10, "t3_m0_done");
        wait_done(3, 2,  "t3_m1_done");
        repeat (4) step();
`ifdef MEM_ARB_STATS_EN
        check("t3_grant_cnt0", 32'(gc0_b), 3);
        check("t3_grant_cnt1", 32'(gc1_b), 1);
        check("t3_cut_cnt2",   32'(cut_b), 2);
`endif

        // 6: reset mid-burst -> outputs drop asynchronously, first grant afterwards is m0
        sl_delay[0] = 0; sl_beats[0] = 1000;
        issue(0, 1'b0, 8, 24'h000500, 32'h0);
        wait_done(0, 3, "t6_three");
        issue(1, 1'b0, 2, 24'h000700, 32'h0);
        reset_n = 1'b0;
        #1;
        check("t6_async_req",   32'(mreq[0]), 0);
        check("t6_async_ready", 32'(rdy[0]), 0);
        check("t6_async_addr",  32'(madr[0]), 0);
        check("t6_async_wdata", mwd[0], 0);
        repeat (2) step();
        reset_n = 1'b1;
        c = 0;
        while (!mreq[0] && c < 20) begin
            step();
            c++;
        end
        check("t6_regrant_req",  32'(mreq[0]), 1);
        check("t6_regrant_addr", 32'(madr[0]), 32'h503);
        check("t6_regrant_l4",   32'(ml4[0]), 0);
        wait_done(0, 8, "t6_m0_done");
        wait_done(1, 2, "t6_m1_done");
        repeat (4) step();

        check("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
